// File: rtl/dequeue_agent_v0_1_pkg.sv
// rtl/dequeue_agent_v0_1_pkg.sv - shared state encoding and sizing for the dequeue agent
package dequeue_agent_v0_1_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_WAIT = 2'd2,
        ST_READ = 2'd3
    } deq_state_e;

    localparam int DEQ_NUM_PORTS = 5;
    localparam int DEQ_CNT_W     = 32;

endpackage

// File: rtl/dequeue_agent_v0_1_port_fsm.sv
// rtl/dequeue_agent_v0_1_port_fsm.sv - one port's pop/wait/read sequencer (module dequeue_port_fsm)
// Optional per-port packet counter built when DEQ_PKT_COUNT_EN is defined.
module dequeue_port_fsm
    import dequeue_agent_v0_1_pkg::*;
#(
    parameter int PIFO_RD_LAT = 1
) (
    input  logic                 i_clk,
    input  logic                 i_resetn,
    input  logic                 i_pifo_empty,
    input  logic                 i_buffer_empty,
    input  logic                 i_buffer_last,
    input  logic                 i_port_ready,
    output logic                 o_pifo_out_en,
    output logic                 o_buffer_rd_en,
    output logic [DEQ_CNT_W-1:0] o_pkt_count
);

    // Loaded in POP so WAIT spans exactly PIFO_RD_LAT cycles (counter hits 0 on the last one).
    localparam logic [2:0] LAT_LOAD = (PIFO_RD_LAT > 0) ? 3'(PIFO_RD_LAT - 1) : 3'd0;

    deq_state_e r_state;
    deq_state_e w_next;
    logic [2:0] r_wait_cnt;
    logic       w_rd_en;

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 3'd0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_POP) begin
                r_wait_cnt <= LAT_LOAD;
            end else if (r_state == ST_WAIT && r_wait_cnt != 3'd0) begin
                r_wait_cnt <= r_wait_cnt - 3'd1;
            end
        end
    end

    always_comb begin
        w_next  = r_state;
        w_rd_en = 1'b0;
        case (r_state)
            ST_IDLE: if (!i_pifo_empty && i_port_ready) w_next = ST_POP;
            ST_POP:  w_next = (PIFO_RD_LAT > 0) ? ST_WAIT : ST_READ;
            ST_WAIT: if (r_wait_cnt == 3'd0) w_next = ST_READ;
            ST_READ: begin
                w_rd_en = i_port_ready && !i_buffer_empty;
                if (w_rd_en && i_buffer_last) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign o_pifo_out_en  = (r_state == ST_POP);
    assign o_buffer_rd_en = w_rd_en;

`ifdef DEQ_PKT_COUNT_EN
    logic                 w_pkt_done;
    logic [DEQ_CNT_W-1:0] r_pkt_count;

    assign w_pkt_done = (r_state == ST_READ) && w_rd_en && i_buffer_last;

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_pkt_count <= '0;
        end else if (w_pkt_done) begin
            r_pkt_count <= r_pkt_count + 1'b1;
        end
    end

    assign o_pkt_count = r_pkt_count;
`else
    assign o_pkt_count = '0;
`endif

endmodule

// File: rtl/dequeue_agent_v0_1.sv
// rtl/dequeue_agent_v0_1.sv - per-port dequeue agent top with optional packet counters
// Counter read path built when DEQ_PKT_COUNT_EN is defined; otherwise CPU outputs are tied to 0.
module dequeue_agent_v0_1
    import dequeue_agent_v0_1_pkg::*;
#(
    parameter int NUM_PORTS   = DEQ_NUM_PORTS,
    parameter int PIFO_RD_LAT = 1
) (
    input  logic                 axis_aclk,
    input  logic                 axis_resetn,
    input  logic [NUM_PORTS-1:0] s_axis_pifo_empty,
    input  logic [NUM_PORTS-1:0] s_axis_buffer_empty,
    input  logic [NUM_PORTS-1:0] s_axis_buffer_last,
    input  logic [NUM_PORTS-1:0] m_axis_port_ready,
    output logic [NUM_PORTS-1:0] m_axis_ctl_pifo_out_en,
    output logic [NUM_PORTS-1:0] m_axis_ctl_buffer_rd_en,
    output logic                 m_axis_valid,
    input  logic [2:0]           s_axi_addr,
    input  logic                 s_axi_req_valid,
    output logic [31:0]          m_axi_data,
    output logic                 m_axi_resp_valid
);

    logic [NUM_PORTS-1:0]                w_pop;
    logic [NUM_PORTS-1:0]                w_rd_en;
    logic [NUM_PORTS-1:0][DEQ_CNT_W-1:0] w_cnt;

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        dequeue_port_fsm #(
            .PIFO_RD_LAT(PIFO_RD_LAT)
        ) u_port (
            .i_clk         (axis_aclk),
            .i_resetn      (axis_resetn),
            .i_pifo_empty  (s_axis_pifo_empty[gi]),
            .i_buffer_empty(s_axis_buffer_empty[gi]),
            .i_buffer_last (s_axis_buffer_last[gi]),
            .i_port_ready  (m_axis_port_ready[gi]),
            .o_pifo_out_en (w_pop[gi]),
            .o_buffer_rd_en(w_rd_en[gi]),
            .o_pkt_count   (w_cnt[gi])
        );
    end

    // Outputs are forced low while reset is held, not only after the reset edge.
    assign m_axis_ctl_pifo_out_en  = w_pop & {NUM_PORTS{axis_resetn}};
    assign m_axis_ctl_buffer_rd_en = w_rd_en & {NUM_PORTS{axis_resetn}};
    assign m_axis_valid            = |m_axis_ctl_buffer_rd_en;

`ifdef DEQ_PKT_COUNT_EN
    logic [31:0] w_sel_data;
    logic [31:0] r_axi_data;
    logic        r_resp_valid;

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (int'(s_axi_addr) == i) w_sel_data = w_cnt[i];
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (!axis_resetn) begin
            r_axi_data   <= '0;
            r_resp_valid <= 1'b0;
        end else begin
            r_axi_data   <= s_axi_req_valid ? w_sel_data : '0;
            r_resp_valid <= s_axi_req_valid;
        end
    end

    assign m_axi_data       = r_axi_data & {32{axis_resetn}};
    assign m_axi_resp_valid = r_resp_valid & axis_resetn;
`else
    logic w_unused_cpu;
    assign w_unused_cpu     = ^{w_cnt, s_axi_addr, s_axi_req_valid};
    assign m_axi_data       = '0;
    assign m_axi_resp_valid = 1'b0;
`endif

endmodule

// File: tb/tb_dequeue_agent_v0_1.sv
// tb/tb_dequeue_agent_v0_1.sv - randomized and directed bench for dequeue_agent_v0_1 (latency 1 and 0)
module tb_dequeue_agent_v0_1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn;
    logic [4:0] pe, be, bl, rdy;
    logic [2:0] addr;
    logic       rq;

    logic [4:0]  pop1, rd1, pop0, rd0;
    logic        v1, v0, rv1, rv0;
    logic [31:0] d1, d0;

    dequeue_agent_v0_1 #(.NUM_PORTS(5), .PIFO_RD_LAT(1)) u_dut1 (
        .axis_aclk(clk), .axis_resetn(resetn),
        .s_axis_pifo_empty(pe), .s_axis_buffer_empty(be), .s_axis_buffer_last(bl),
        .m_axis_port_ready(rdy), .m_axis_ctl_pifo_out_en(pop1), .m_axis_ctl_buffer_rd_en(rd1),
        .m_axis_valid(v1), .s_axi_addr(addr), .s_axi_req_valid(rq),
        .m_axi_data(d1), .m_axi_resp_valid(rv1)
    );

    dequeue_agent_v0_1 #(.NUM_PORTS(5), .PIFO_RD_LAT(0)) u_dut0 (
        .axis_aclk(clk), .axis_resetn(resetn),
        .s_axis_pifo_empty(pe), .s_axis_buffer_empty(be), .s_axis_buffer_last(bl),
        .m_axis_port_ready(rdy), .m_axis_ctl_pifo_out_en(pop0), .m_axis_ctl_buffer_rd_en(rd0),
        .m_axis_valid(v0), .s_axi_addr(addr), .s_axi_req_valid(rq),
        .m_axi_data(d0), .m_axi_resp_valid(rv0)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: per port, cycles elapsed since its pop (-1 = no packet). Index d is also the latency.
    int          age  [2][5];
    logic [31:0] pcnt [2][5];
    logic [31:0] exp_data [2];
    logic        exp_resp;

    function automatic logic exp_rd(int a, int lat, logic r, logic e);
        return (a > lat) && r && !e;
    endfunction

    task automatic step(input logic i_rstn, input logic [4:0] i_pe, input logic [4:0] i_be,
                        input logic [4:0] i_bl, input logic [4:0] i_rdy,
                        input logic [2:0] i_addr, input logic i_rq);
        logic [4:0]  ep [2];
        logic [4:0]  er [2];
        logic [4:0]  op [2];
        logic [4:0]  orr[2];
        logic        ov [2];
        logic        orv[2];
        logic [31:0] od [2];
        @(posedge clk);
        #1;
        resetn = i_rstn; pe = i_pe; be = i_be; bl = i_bl; rdy = i_rdy; addr = i_addr; rq = i_rq;
        #1;
        op[0] = pop0; orr[0] = rd0; ov[0] = v0; od[0] = d0; orv[0] = rv0;
        op[1] = pop1; orr[1] = rd1; ov[1] = v1; od[1] = d1; orv[1] = rv1;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 5; p++) begin
                ep[d][p] = i_rstn && (age[d][p] == 0);
                er[d][p] = i_rstn && exp_rd(age[d][p], d, i_rdy[p], i_be[p]);
            end
            check_eq($sformatf("pifo_out_en lat%0d", d), 32'(op[d]), 32'(ep[d]));
            check_eq($sformatf("buffer_rd_en lat%0d", d), 32'(orr[d]), 32'(er[d]));
            check_eq($sformatf("valid lat%0d", d), 32'(ov[d]), 32'(|er[d]));
            check_eq($sformatf("axi_data lat%0d", d), od[d], i_rstn ? exp_data[d] : 32'd0);
            check_eq($sformatf("axi_resp lat%0d", d), 32'(orv[d]), 32'(i_rstn && exp_resp));
        end
        if (!i_rstn) begin
            exp_resp = 1'b0;
            for (int d = 0; d < 2; d++) begin
                exp_data[d] = '0;
                for (int p = 0; p < 5; p++) begin
                    age[d][p]  = -1;
                    pcnt[d][p] = '0;
                end
            end
        end else begin
`ifdef DEQ_PKT_COUNT_EN
            exp_resp = i_rq;
            for (int d = 0; d < 2; d++)
                exp_data[d] = (i_rq && i_addr < 3'd5) ? pcnt[d][i_addr] : 32'd0;
`else
            exp_resp = 1'b0;
            exp_data[0] = '0;
            exp_data[1] = '0;
`endif
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < 5; p++) begin
                    if (age[d][p] < 0) begin
                        age[d][p] = (!i_pe[p] && i_rdy[p]) ? 0 : -1;
                    end else if (er[d][p] && i_bl[p]) begin
                        age[d][p]  = -1;
                        pcnt[d][p] = pcnt[d][p] + 1;
                    end else if (age[d][p] < 50) begin
                        age[d][p]++;
                    end
                end
            end
        end
    endtask

    // Directed packet run; last flit is paced by the latency-1 instance's observed reads.
    task automatic run_pkt(input logic [4:0] ports, input int len, input int stall_port, input string tag);
        int         sent[5];
        logic [4:0] popped;
        logic [4:0] lpe, lbl, lrdy;
        int         stall_cnt, pops, rds, pair, cp1, cr1, cp0, cr0;
        popped = '0; stall_cnt = 0; pops = 0; rds = 0; pair = 0;
        cp1 = -1; cr1 = -1; cp0 = -1; cr0 = -1;
        for (int p = 0; p < 5; p++) sent[p] = 0;
        for (int c = 0; c < 30; c++) begin
            lpe  = ~(ports & ~popped);
            lrdy = '1;
            for (int p = 0; p < 5; p++) lbl[p] = (sent[p] == len - 1);
            if (stall_port < 5 && sent[stall_port] == 1 && stall_cnt < 2) begin
                lrdy[stall_port] = 1'b0;
                stall_cnt++;
            end
            step(1'b1, lpe, 5'b0, lbl, lrdy, 3'd0, 1'b0);
            popped |= pop1;
            pops += $countones(pop1);
            rds  += $countones(rd1);
            if (pop1 != 0 && cp1 < 0) cp1 = c;
            if (rd1  != 0 && cr1 < 0) cr1 = c;
            if (pop0 != 0 && cp0 < 0) cp0 = c;
            if (rd0  != 0 && cr0 < 0) cr0 = c;
            if (rd1 == ports && v1) pair++;
            for (int p = 0; p < 5; p++) if (rd1[p]) sent[p]++;
        end
        check_eq({tag, " pops"}, 32'(pops), 32'($countones(ports)));
        check_eq({tag, " flits"}, 32'(rds), 32'(len * $countones(ports)));
        check_eq({tag, " first rd lat1"}, 32'(cr1 - cp1), 32'd2);
        check_eq({tag, " first rd lat0"}, 32'(cr0 - cp0), 32'd1);
        if ($countones(ports) > 1) check_eq({tag, " joint rd"}, 32'(pair), 32'(len));
    endtask

    function automatic logic [4:0] rbits(int pct);
        logic [4:0] b;
        for (int i = 0; i < 5; i++) b[i] = ($urandom_range(0, 99) < pct);
        return b;
    endfunction

    initial begin
        resetn = 1'b0; pe = '1; be = '1; bl = '0; rdy = '0; addr = '0; rq = 1'b0;
        exp_resp = 1'b0;
        for (int d = 0; d < 2; d++) begin
            exp_data[d] = '0;
            for (int p = 0; p < 5; p++) begin
                age[d][p] = -1;
                pcnt[d][p] = '0;
            end
        end

        repeat (3) step(1'b0, 5'b0, 5'b0, 5'b0, 5'h1f, 3'd1, 1'b1);
        repeat (2) step(1'b1, 5'h1f, 5'b0, 5'b0, 5'h1f, 3'd0, 1'b0);

        run_pkt(5'b00001, 3, 9, "port0 3 flits");
        run_pkt(5'b00100, 4, 2, "port2 stall");
        run_pkt(5'b10001, 2, 9, "ports 0+4");

        // Reset while latency-1 instance sits in WAIT, then while in READ.
        step(1'b1, 5'b10111, 5'b0, 5'b0, 5'h1f, 3'd0, 1'b0);
        step(1'b1, 5'h1f,    5'b0, 5'b0, 5'h1f, 3'd0, 1'b0);
        step(1'b1, 5'h1f,    5'b0, 5'b0, 5'h1f, 3'd0, 1'b0);
        step(1'b0, 5'h1f,    5'b0, 5'b0, 5'h1f, 3'd0, 1'b0);
        check_eq("reset in wait rd_en", 32'(rd1 | pop1), 32'd0);
        step(1'b1, 5'b10111, 5'b0, 5'b0, 5'h1f, 3'd0, 1'b0);
        step(1'b1, 5'h1f,    5'b0, 5'b0, 5'h1f, 3'd0, 1'b0);
        step(1'b1, 5'h1f,    5'b0, 5'b0, 5'h1f, 3'd0, 1'b0);
        step(1'b1, 5'h1f,    5'b0, 5'b0, 5'h1f, 3'd0, 1'b0);
        step(1'b0, 5'h1f,    5'b0, 5'b0, 5'h1f, 3'd0, 1'b0);
        check_eq("reset in read outputs", 32'({rd1, pop1, v1}), 32'd0);
        repeat (4) step(1'b1, 5'h1f, 5'b0, 5'b0, 5'h1f, 3'd0, 1'b0);
        check_eq("idle after reset", 32'({pop1, pop0}), 32'd0);

        repeat (3) run_pkt(5'b00010, 2, 9, "port1 count");
        step(1'b1, 5'h1f, 5'b0, 5'b0, 5'h1f, 3'd1, 1'b1);
        step(1'b1, 5'h1f, 5'b0, 5'b0, 5'h1f, 3'd6, 1'b1);
`ifdef DEQ_PKT_COUNT_EN
        check_eq("count port1 data", d1, 32'd3);
        check_eq("count port1 resp", 32'(rv1), 32'd1);
`else
        check_eq("count tied data", d1, 32'd0);
        check_eq("count tied resp", 32'(rv1), 32'd0);
`endif
        step(1'b1, 5'h1f, 5'b0, 5'b0, 5'h1f, 3'd0, 1'b0);
        check_eq("oob addr data", d1, 32'd0);
`ifdef DEQ_PKT_COUNT_EN
        check_eq("oob addr resp", 32'(rv1), 32'd1);
`endif

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 299) != 0, rbits(50), rbits(25), rbits(35), rbits(75),
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
